// File: rtl/ndata_serializer_pkg.sv
// Shared helpers for wide-to-narrow stream serialization: lane index width,
// lowest-set-lane priority encoding and the "at most one lane left" test.
package ndata_serializer_pkg;

  // Widest lane mask the helper functions handle; callers zero-extend.
  localparam int MAX_LANES = 32;

  // Index width for a lane count, never narrower than one bit.
  function automatic int idxWidth(input int numLanes);
    return (numLanes > 1) ? $clog2(numLanes) : 1;
  endfunction

  // Index of the lowest set bit, or 0 when the vector is empty.
  function automatic int lowestOneIdx(input logic [MAX_LANES-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  // True when zero or one bit is set, i.e. the element shown is the final one.
  function automatic logic atMostOneSet(input logic [MAX_LANES-1:0] vec);
    return (vec & (vec - MAX_LANES'(1))) == '0;
  endfunction

endpackage

// File: rtl/ndata_serializer.sv
// Serializes a wide multi-lane beat into one element per output beat,
// skipping lanes whose keep bit is clear, in ascending lane order.
module ndata_serializer
  import ndata_serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ELEMENTS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] inData_i,
  input  logic [NUM_ELEMENTS-1:0]            inKeep_i,
  input  logic                               inLast_i,
  input  logic                               inValid_i,
  output logic                               inReady_o,
  output logic [DATA_WIDTH-1:0]              outData_o,
  output logic                               outKeep_o,
  output logic                               outLast_o,
  output logic                               outValid_o,
  input  logic                               outReady_i
);

  localparam int IDX_W = idxWidth(NUM_ELEMENTS);

  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] bufData_q, bufData_d;
  logic [NUM_ELEMENTS-1:0]                 remMask_q, remMask_d;
  logic                                    bufLast_q, bufLast_d;
  logic                                    bufValid_q, bufValid_d;

  logic [MAX_LANES-1:0] remWide;
  logic [IDX_W-1:0]     lowIdx;
  logic                 finalElem;
  logic                 outFire;
  logic                 inFire;
  logic                 loadBeat;

  assign remWide   = MAX_LANES'(remMask_q);
  assign lowIdx    = IDX_W'(lowestOneIdx(remWide));
  assign finalElem = atMostOneSet(remWide);

  assign outValid_o = bufValid_q;
  assign outKeep_o  = |remMask_q;
  assign outLast_o  = bufLast_q && finalElem;

  // The next beat may enter in the same cycle the held beat's final element leaves.
  assign inReady_o = !bufValid_q || (outReady_i && finalElem);
  assign outFire   = bufValid_q && outReady_i;
  assign inFire    = inValid_i && inReady_o;
  assign loadBeat  = inFire && ((|inKeep_i) || inLast_i);

  // Present the lowest still-pending lane of the held beat.
  always_comb begin
    outData_o = bufData_q[0];
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (i == int'(lowIdx)) outData_o = bufData_q[i];
    end
  end

  // Retire the emitted lane, then let a newly accepted beat overwrite the buffer.
  always_comb begin
    bufData_d  = bufData_q;
    remMask_d  = remMask_q;
    bufLast_d  = bufLast_q;
    bufValid_d = bufValid_q;
    if (outFire) begin
      remMask_d = remMask_q & (remMask_q - NUM_ELEMENTS'(1));
      if (finalElem) bufValid_d = 1'b0;
    end
    if (loadBeat) begin
      bufData_d  = inData_i;
      remMask_d  = inKeep_i;
      bufLast_d  = inLast_i;
      bufValid_d = 1'b1;
    end
  end

  // Buffer registers; reset drops any partly emitted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufData_q  <= '0;
      remMask_q  <= '0;
      bufLast_q  <= 1'b0;
      bufValid_q <= 1'b0;
    end else begin
      bufData_q  <= bufData_d;
      remMask_q  <= remMask_d;
      bufLast_q  <= bufLast_d;
      bufValid_q <= bufValid_d;
    end
  end

endmodule

// File: doc/ndata_serializer.md
Name: ndata_serializer

Overview:
- Converts a wide `ndata_i` stream (NUM_ELEMENTS lanes per beat, per-lane keep) into a narrow `data_i` stream carrying one element per beat.
- Elements with keep=0 are skipped, so the output is packed.
- Sits downstream of wide datapath stages (e.g. after parallel filters) and feeds single-element consumers.
- It is the inverse of an element packer.

Parameters:
- data_t, logic[31:0], element type of both streams.
- NUM_ELEMENTS, 4, lanes per input beat; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  ndata_i.s  NUM_ELEMENTS x data_t + NUM_ELEMENTS keep + last/valid/ready  wide input stream.
- out  data_i.m  data_t + keep/last/valid/ready  serialized output stream.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- State:
  - buf_data[NUM_ELEMENTS]
  - rem_mask[NUM_ELEMENTS], lanes not yet emitted
  - buf_last
  - buf_valid
- Reset values: buf_valid=0, rem_mask=0, buf_last=0, buf_data don't-care.
  - While rst is high: out.valid=0, in.ready=1.
  - Reset mid-beat discards the held beat; no partial replay.
- Output (combinational from state):
  - out.valid = buf_valid.
  - out.data = buf_data[idx], idx = lowest set bit of rem_mask (0 if rem_mask=0).
  - out.keep = |rem_mask.
  - out.last = buf_last && popcount(rem_mask) <= 1.
- Input ready: in.ready = !buf_valid || (out.ready && popcount(rem_mask) <= 1).
  - A new beat is accepted in the same cycle the final element of the held beat transfers, so there is no bubble.
  - in.ready has a combinational path from out.ready.
- Input accept (in.valid && in.ready):
  - keep=0 and last=0: beat is consumed and dropped; nothing loaded. If the held beat also finished this cycle, buf_valid goes to 0.
  - Otherwise: buf_data=in.data, rem_mask=in.keep, buf_last=in.last, buf_valid=1.
  - keep=0 and last=1: emits exactly one output beat with keep=0, last=1, data don't-care, so that last is never lost.
- Output transfer (out.valid && out.ready):
  - Clears the lowest set bit of rem_mask.
  - If this was the final element (popcount <= 1) and no new beat loads, buf_valid goes to 0.
- Ordering and timing:
  - Output order is ascending lane index.
  - Latency is 1 cycle from input accept to first output valid.
  - Throughput is 1 element per cycle. An input beat with k kept lanes occupies k cycles (1 if k=0 and last=1).
- Stability: while out.valid=1 and out.ready=0, out.data/keep/last hold stable.
- NUM_ELEMENTS=1 degenerates to a registered pass-through at full rate.

Decomposition:
- Shared package (libstf-wide):
  - Function for lowest-set-bit index over a NUM_ELEMENTS vector.
  - Function for the popcount <= 1 test.
  - Index width constant $clog2(NUM_ELEMENTS) with a minimum of 1.
- No sub-module required. If split, the single natural candidate is a priority encoder "lowest_one_idx".

Test Plan (NUM_ELEMENTS=4, data_t=logic[7:0]):
- Full beat: data={0x44,0x33,0x22,0x11}, keep=4'b1111, last=1, out.ready=1.
  - Required: outputs 0x11,0x22,0x33,0x44 on 4 consecutive cycles, first one cycle after accept.
  - last=1 only on 0x44; in.ready low for 3 cycles and high in the cycle 0x44 transfers.
- Sparse keep: keep=4'b1010, data={0xD,0xC,0xB,0xA}, last=1.
  - Required: exactly 0xB then 0xD, last on 0xD, keep=1 on both.
- Empty beats:
  - keep=0, last=0 is dropped with no output beat and in.ready stays 1.
  - keep=0, last=1 produces one beat with keep=0, last=1.
- Back-to-back with random out.ready (30% low), 200 random beats.
  - Required: output equals the packed kept-lane sequence, last count matches input last count.
  - Data stable under stall; no bubble when out.ready=1 continuously.
- Reset asserted asynchronously while 2 of 4 lanes are pending.
  - Required: out.valid=0 immediately, in.ready=1.
  - After release, the next beat serializes correctly with no leftover elements.
